// File: rtl/pc_ctrl_dmem.sv
// pc_ctrl_dmem
// Support block for a single-cycle MIPS-subset core: program-counter
// register, main control decoder and a word-organised data memory.
//
// Ports
//   clock      in   1  rising-edge system clock
//   reset      in   1  asynchronous, active-low reset (pc and memory)
//   nextPC     in  32  next program counter from the PCSrc mux
//   pc         out 32  current program counter
//   opcode     in   6  instruction[31:26]
//   funct      in   6  instruction[5:0]
//   ALUOp      out  3  ALU-control class code
//   ALUSrc     out  1  ALU operand 2 is the sign-extended immediate
//   RegDst     out  1  write register is rd (1) or rt (0)
//   RegWrite   out  1  register-file write enable
//   MemtoReg   out  1  writeback data comes from memory
//   MemRead    out  1  data-memory read enable
//   MemWrite   out  1  data-memory write enable
//   Branch     out  1  conditional branch (beq)
//   Jump       out  1  unconditional jump (j, jr)
//   Address    in  32  data-memory byte address (ALU result)
//   WriteData  in  32  store data
//   ReadData   out 32  load data (zero unless MemRead)
module pc_ctrl_dmem #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] nextPC,
    output logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  ALUOp,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_mem [0:DEPTH-1];
    // Packed control vector: {ALUOp, ALUSrc, RegDst, RegWrite, MemtoReg,
    //                         MemRead, MemWrite, Branch, Jump}
    logic [10:0]   w_ctrl;
    logic [AW-1:0] w_index;
    logic [31:0]   w_read_data;
    logic          w_unused_addr;

    // Word index: byte-offset bits and bits above the memory size are
    // dropped, so accesses are word-aligned and wrap modulo DEPTH*4.
    assign w_index       = Address[AW+1:2];
    assign w_unused_addr = ^{Address[31:AW+2], Address[1:0]};

    // Program counter: async reset to PC_RESET, otherwise load every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= nextPC;
        end
    end

    // Main control decoder; unknown opcodes decode to all-zero so they
    // can never write the register file or memory.
    always_comb begin
        w_ctrl = 11'b000_0000_0000;
        case (opcode)
            6'b000000: begin
                if (funct == 6'b001000) begin
                    w_ctrl = 11'b010_0_0_0_0_0_0_0_1;   // jr
                end else begin
                    w_ctrl = 11'b010_0_1_1_0_0_0_0_0;   // R-type
                end
            end
            6'b001000: w_ctrl = 11'b000_1_0_1_0_0_0_0_0; // addi
            6'b001100: w_ctrl = 11'b011_1_0_1_0_0_0_0_0; // andi
            6'b001101: w_ctrl = 11'b100_1_0_1_0_0_0_0_0; // ori
            6'b001010: w_ctrl = 11'b101_1_0_1_0_0_0_0_0; // slti
            6'b100011: w_ctrl = 11'b000_1_0_1_1_1_0_0_0; // lw
            6'b101011: w_ctrl = 11'b000_1_0_0_0_0_1_0_0; // sw
            6'b000100: w_ctrl = 11'b001_0_0_0_0_0_0_1_0; // beq
            6'b000010: w_ctrl = 11'b111_0_0_0_0_0_0_0_1; // j
            default:   w_ctrl = 11'b000_0000_0000;
        endcase
    end

    // Data memory: async clear of every word, synchronous word write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_ctrl[2]) begin
            r_mem[w_index] <= WriteData;
        end else begin
            r_mem[w_index] <= r_mem[w_index];
        end
    end

    // Combinational read, gated to zero when MemRead is low.
    always_comb begin
        w_read_data = 32'h0000_0000;
        if (w_ctrl[3]) begin
            w_read_data = r_mem[w_index];
        end else begin
            w_read_data = 32'h0000_0000;
        end
    end

    assign pc       = r_pc;
    assign ALUOp    = w_ctrl[10:8];
    assign ALUSrc   = w_ctrl[7];
    assign RegDst   = w_ctrl[6];
    assign RegWrite = w_ctrl[5];
    assign MemtoReg = w_ctrl[4];
    assign MemRead  = w_ctrl[3];
    assign MemWrite = w_ctrl[2];
    assign Branch   = w_ctrl[1];
    assign Jump     = w_ctrl[0];
    assign ReadData = w_read_data;

endmodule

// File: tb/tb_pc_ctrl_dmem.sv
// Testbench for pc_ctrl_dmem: directed plan steps followed by random
// steps; expected outputs come from a table-driven reference model and
// are queued, and a negedge monitor pops and compares them.
module tb_pc_ctrl_dmem;

    localparam int          DEPTH    = 256;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] nextPC;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [2:0]  ALUOp;
    logic        ALUSrc, RegDst, RegWrite, MemtoReg;
    logic        MemRead, MemWrite, Branch, Jump;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    pc_ctrl_dmem #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clock(clock), .reset(reset), .nextPC(nextPC), .pc(pc),
        .opcode(opcode), .funct(funct), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .Jump(Jump), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [10:0] ctrl;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    logic [10:0] ctrl_tbl [bit [5:0]];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Control vector from the instruction table; {ALUOp, ALUSrc, RegDst,
    // RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump}
    function automatic logic [10:0] model_ctrl(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0 && fn == 6'b001000) return 11'b010_0_0_0_0_0_0_0_1;
        if (ctrl_tbl.exists(op)) return ctrl_tbl[op];
        return 11'd0;
    endfunction

    // Issue one cycle of stimulus; expectations describe what the DUT shows
    // at the following negedge, then the model applies the next posedge.
    task automatic step(input string nm, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] npc);
        exp_t        e;
        logic [10:0] c;
        int          idx;
        @(posedge clock);
        #1;
        reset = rst; opcode = op; funct = fn; Address = addr;
        WriteData = wd; nextPC = npc;
        if (!rst) begin
            m_pc = PC_RESET;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        end
        c   = model_ctrl(op, fn);
        idx = int'((addr / 32'd4) % DEPTH);
        e.name = nm;
        e.pc   = m_pc;
        e.ctrl = c;
        e.rd   = c[3] ? m_mem[idx] : 32'd0;
        sb.push_back(e);
        if (rst) begin
            if (c[2]) m_mem[idx] = wd;
            m_pc = npc;
        end
    endtask

    // Monitor: compare the oldest expectation at every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".pc"}, pc, e.pc);
                check({e.name, ".ctrl"}, {21'd0, ALUOp, ALUSrc, RegDst, RegWrite,
                      MemtoReg, MemRead, MemWrite, Branch, Jump}, {21'd0, e.ctrl});
                check({e.name, ".rd"}, ReadData, e.rd);
            end
        end
    end

    logic [5:0] ops [12];

    initial begin
        ctrl_tbl[6'b000000] = 11'b010_0_1_1_0_0_0_0_0;
        ctrl_tbl[6'b001000] = 11'b000_1_0_1_0_0_0_0_0;
        ctrl_tbl[6'b001100] = 11'b011_1_0_1_0_0_0_0_0;
        ctrl_tbl[6'b001101] = 11'b100_1_0_1_0_0_0_0_0;
        ctrl_tbl[6'b001010] = 11'b101_1_0_1_0_0_0_0_0;
        ctrl_tbl[6'b100011] = 11'b000_1_0_1_1_1_0_0_0;
        ctrl_tbl[6'b101011] = 11'b000_1_0_0_0_0_1_0_0;
        ctrl_tbl[6'b000100] = 11'b001_0_0_0_0_0_0_1_0;
        ctrl_tbl[6'b000010] = 11'b111_0_0_0_0_0_0_0_1;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04,
                6'h02, 6'h3F, 6'h23, 6'h2B};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_pc = PC_RESET;

        reset = 1'b1; nextPC = 32'd0; opcode = 6'd0; funct = 6'd0;
        Address = 32'd0; WriteData = 32'd0;
        #1 reset = 1'b0;

        // Reset hold and PC advance
        step("rst_hold0", 1'b0, 6'h00, 6'h20, 32'h0, 32'h0, 32'h100);
        step("rst_hold1", 1'b0, 6'h00, 6'h20, 32'h0, 32'h0, 32'h100);
        step("release",   1'b1, 6'h00, 6'h20, 32'h0, 32'h0, 32'h4);
        step("pc4",       1'b1, 6'h00, 6'h20, 32'h0, 32'h0, 32'h8);
        step("async_rst", 1'b0, 6'h00, 6'h20, 32'h0, 32'h0, 32'hC);

        // Decoder sweep
        step("rtype",  1'b1, 6'h00, 6'h20, 32'h0, 32'h0, 32'h10);
        step("jr",     1'b1, 6'h00, 6'h08, 32'h0, 32'h0, 32'h14);
        step("addi",   1'b1, 6'h08, 6'h00, 32'h0, 32'h0, 32'h18);
        step("andi",   1'b1, 6'h0C, 6'h00, 32'h0, 32'h0, 32'h1C);
        step("ori",    1'b1, 6'h0D, 6'h00, 32'h0, 32'h0, 32'h20);
        step("slti",   1'b1, 6'h0A, 6'h00, 32'h0, 32'h0, 32'h24);
        step("lw",     1'b1, 6'h23, 6'h00, 32'h0, 32'h0, 32'h28);
        step("sw",     1'b1, 6'h2B, 6'h00, 32'h4, 32'h5A5A5A5A, 32'h2C);
        step("beq",    1'b1, 6'h04, 6'h00, 32'h0, 32'h0, 32'h30);
        step("j",      1'b1, 6'h02, 6'h00, 32'h0, 32'h0, 32'h34);
        step("illegal",1'b1, 6'h3F, 6'h00, 32'h0, 32'h0, 32'h38);

        // lw/sw round trip, alignment and wrap
        step("sw10",   1'b1, 6'h2B, 6'h00, 32'h10, 32'hDEADBEEF, 32'h3C);
        step("lw10",   1'b1, 6'h23, 6'h00, 32'h10, 32'h0, 32'h40);
        step("sw20",   1'b1, 6'h2B, 6'h00, 32'h20, 32'h12345678, 32'h44);
        step("lw23",   1'b1, 6'h23, 6'h00, 32'h23, 32'h0, 32'h48);
        step("lwwrap", 1'b1, 6'h23, 6'h00, 32'h20 + DEPTH * 4, 32'h0, 32'h4C);

        // Read gating and memory reset
        step("gate",   1'b1, 6'h00, 6'h20, 32'h20, 32'h0, 32'h50);
        step("mrst",   1'b0, 6'h23, 6'h00, 32'h20, 32'h0, 32'h54);
        step("lwclr",  1'b1, 6'h23, 6'h00, 32'h20, 32'h0, 32'h58);

        // Illegal-op safety
        step("sw10b",  1'b1, 6'h2B, 6'h00, 32'h10, 32'hDEADBEEF, 32'h5C);
        step("ill_wr", 1'b1, 6'h3F, 6'h00, 32'h10, 32'hFFFFFFFF, 32'h60);
        step("lw10b",  1'b1, 6'h23, 6'h00, 32'h10, 32'h0, 32'h64);

        // Random traffic over a small set of colliding words
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  op;
            logic [5:0]  fn;
            logic [31:0] ad;
            logic        rs;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                              : ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
            ad = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            rs = ($urandom_range(0, 39) != 0);
            step("rand", rs, op, fn, ad, $urandom, $urandom);
        end

        repeat (3) @(posedge clock);
        check("drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
